// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// FSM state encoding and requester port ids.
package dmem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way request pick for the data-memory arbiter.
// Tie policy: round-robin when DMEM_ARB_RR_EN is defined, else fixed.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO_PORT = 0
) (
`ifdef DMEM_ARB_RR_EN
    input  logic clk,
`endif
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic tie_win;
    logic win;

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    // Remember the last granted port; reset value lets port 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT1;
        end else if (gnt0 | gnt1) begin
            last_q <= gnt1;
        end
    end

    assign tie_win = ~last_q;
`else
    assign tie_win = (FIXED_PRIO_PORT != 0) ? PORT1 : PORT0;
`endif

    // Select the winning port among the active requests.
    always_comb begin
        win = PORT0;
        unique case (1'b1)
            req0 & req1:  win = tie_win;
            req1 & ~req0: win = PORT1;
            default:      win = PORT0;
        endcase
    end

    assign gnt0 = ~rst & en & req0 & (win == PORT0);
    assign gnt1 = ~rst & en & req1 & (win == PORT1);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Tie policy selected by DMEM_ARB_RR_EN (round-robin) else fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int FIXED_PRIO_PORT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic arb_en;
    logic gnt0;
    logic gnt1;
    logic in_access;
    logic in_resp;

    // Arbitration is allowed in IDLE and RESP, never during the access.
    assign arb_en    = (state_q != ACCESS);
    assign in_access = (state_q == ACCESS) & ~rst;
    assign in_resp   = (state_q == RESP) & ~rst;

    dmem_arb_pick #(
        .FIXED_PRIO_PORT(FIXED_PRIO_PORT)
    ) u_pick (
`ifdef DMEM_ARB_RR_EN
        .clk (clk),
`endif
        .rst (rst),
        .en  (arb_en),
        .req0(m0_req),
        .req1(m1_req),
        .gnt0(gnt0),
        .gnt1(gnt1)
    );

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    assign mem_read  = in_access & ~we_q;
    assign mem_write = in_access & we_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

    assign m0_rvalid = in_resp & (owner_q == PORT0);
    assign m1_rvalid = in_resp & (owner_q == PORT1);
    assign m0_rdata  = m0_rvalid ? rdata_q : '0;
    assign m1_rdata  = m1_rvalid ? rdata_q : '0;

    // Sequencer: latch the winner, access memory once, then respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= PORT0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (gnt0 | gnt1) begin
                        owner_q <= gnt1;
                        we_q    <= gnt1 ? m1_we : m0_we;
                        addr_q  <= gnt1 ? m1_addr : m0_addr;
                        wdata_q <= gnt1 ? m1_wdata : m0_wdata;
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : mem_rdata;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data memory.
// Expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    localparam int FP = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem  [0:255] = '{default: '0};
    logic [31:0] refm [0:255] = '{default: '0};

    txn_t        sbq [2][$];
    int          glog_port [$];
    int          glog_cyc [$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cycles = 0;
    logic [31:0] wr_addr = 0;
    int          n_rv = 0;
    logic [31:0] last_rd [2];

    logic [1:0]  gv, rv;
    logic [31:0] rdv [2];

    assign gv     = {m1_gnt, m0_gnt};
    assign rv     = {m1_rvalid, m0_rvalid};
    assign rdv[0] = m0_rdata;
    assign rdv[1] = m1_rdata;

    dmem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .FIXED_PRIO_PORT(FP)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, posedge write.
    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: invariants, completion checking and grant capture.
    always @(negedge clk) begin
        if (rst) begin
            sbq[0].delete();
            sbq[1].delete();
            chk("rst_quiet", {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                              mem_read, mem_write}, 32'd0);
        end else begin
            chk("gnt_excl", {31'd0, m0_gnt & m1_gnt}, 32'd0);
            chk("rw_excl", {31'd0, mem_read & mem_write}, 32'd0);
            if (mem_write) begin
                wr_cycles++;
                wr_addr = mem_addr;
            end
            for (int p = 0; p < 2; p++) begin
                if (rv[p]) n_rv++;
                if (sbq[p].size() > 0 && sbq[p][0].cyc == cyc) begin
                    txn_t        t;
                    logic [31:0] e;
                    t = sbq[p].pop_front();
                    e = t.we ? 32'h0 : refm[t.addr[9:2]];
                    if (t.we) refm[t.addr[9:2]] = t.wdata;
                    chk($sformatf("rvalid%0d", p), {31'd0, rv[p]}, 32'd1);
                    chk($sformatf("rdata%0d", p), rdv[p], e);
                    last_rd[p] = rdv[p];
                end else if (rv[p]) begin
                    chk($sformatf("spurious_rvalid%0d", p), {31'd0, rv[p]},
                        32'd0);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (gv[p]) begin
                    txn_t t;
                    t.we    = (p == 0) ? m0_we : m1_we;
                    t.addr  = (p == 0) ? m0_addr : m1_addr;
                    t.wdata = (p == 0) ? m0_wdata : m1_wdata;
                    t.cyc   = cyc + 2;
                    sbq[p].push_back(t);
                    glog_port.push_back(p);
                    glog_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic access(input int p, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(p, 1'b1, we, a, d);
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = gv[p];
        end
        if (!got) chk("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((sbq[0].size() + sbq[1].size()) != 0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("drain", sbq[0].size() + sbq[1].size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        glog_port.delete();
        glog_cyc.delete();
    endtask

    task automatic wait_grants(input int n);
        int i;
        i = 0;
        while (glog_port.size() < n && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("grant_count", glog_port.size(), n);
    endtask

    initial begin : stim
        logic [31:0] pre;
        int          rv0;
        int          exp_p;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back through port 0.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 32'h0);
        drain();
        chk("t1_rdata", last_rd[0], 32'hDEADBEEF);

        // Continuous contention from both ports.
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
        wait_grants(4);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        for (int i = 0; i < 4 && i < glog_port.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_p = i % 2;
`else
            exp_p = FP;
`endif
            chk($sformatf("t2_gnt%0d", i), glog_port[i], exp_p);
        end

        // Aliasing above 1 KiB.
        do_reset();
        wr_cycles = 0;
        access(1, 1'b1, 32'h400, 32'h5);
        drain();
        chk("t3_wr_cycles", wr_cycles, 32'd1);
        chk("t3_wr_addr", wr_addr, 32'h400);
        access(1, 1'b0, 32'h0, 32'h0);
        drain();
        chk("t3_alias_rd", last_rd[1], 32'h5);

        // Reset during the access cycle of a write.
        do_reset();
        pre = mem[8];
        rv0 = n_rv;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 32'h20, 32'hAA);
        @(negedge clk);
        chk("t4_gnt", {31'd0, m0_gnt}, 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        glog_port.delete();
        glog_cyc.delete();
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
`ifdef DMEM_ARB_RR_EN
        exp_p = 0;
`else
        exp_p = FP;
`endif
        chk("t4_first_gnt0", {31'd0, m0_gnt}, (exp_p == 0) ? 32'd1 : 32'd0);
        chk("t4_first_gnt1", {31'd0, m1_gnt}, (exp_p == 1) ? 32'd1 : 32'd0);
        chk("t4_no_rvalid", n_rv - rv0, 32'd0);
        chk("t4_mem8", mem[8], pre);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        chk("t4_mem8_final", mem[8], 32'h0);

        // Back-to-back reads with req held high.
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        wait_grants(4);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        for (int i = 0; i + 1 < 4 && i + 1 < glog_cyc.size(); i++) begin
            chk($sformatf("t5_gap%0d", i), glog_cyc[i+1] - glog_cyc[i], 32'd2);
        end
        chk("t5_rdata", last_rd[0], 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
